// File: rtl/alu_pkg.sv
// Shared opcode, flag and limit definitions for the pipelined ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpNot  = 4'd5,
        OpShl  = 4'd6,
        OpShr  = 4'd7,
        OpSra  = 4'd8,
        OpRol  = 4'd9,
        OpSlt  = 4'd10,
        OpSltu = 4'd11
    } alu_op_e;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic illegal;
    } alu_flags_t;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op >= OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/cla_addsub_n.sv
// WIDTH-bit adder/subtractor built from 4-bit carry-lookahead groups with rippled group carries.
module cla_addsub_n #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NGRP = WIDTH / 4;

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NGRP:0]    w_gc;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign w_bx    = b ^ {WIDTH{sub}};
    assign w_g     = a & w_bx;
    assign w_p     = a ^ w_bx;
    assign w_gc[0] = sub;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        logic [3:0] w_gg;
        logic [3:0] w_pp;
        logic [4:0] w_c;

        assign w_gg   = w_g[4*gi +: 4];
        assign w_pp   = w_p[4*gi +: 4];
        assign w_c[0] = w_gc[gi];
        assign w_c[1] = w_gg[0] | (w_pp[0] & w_c[0]);
        assign w_c[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_c[0]);
        assign w_c[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                      | (w_pp[2] & w_pp[1] & w_pp[0] & w_c[0]);
        assign w_c[4] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                      | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                      | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_c[0]);

        assign sum[4*gi +: 4] = w_pp ^ w_c[3:0];
        assign w_gc[gi+1]     = w_c[4];
    end

    assign cout = w_gc[NGRP];
    assign ovf  = (a[WIDTH-1] == w_bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers operands, S2 computes and registers result and flags.
// Optional operand isolation of the compute units is enabled by defining ALU_OPISO_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_op;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    alu_flags_t       r_flags;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_s1_load;
    logic [WIDTH-1:0] w_ua;
    logic [WIDTH-1:0] w_ub;
    logic [3:0]       w_uop;

    assign w_s2_load  = !r_out_valid || out_ready;
    assign w_in_ready = !rst && (!r_s1_valid || w_s2_load);

`ifdef ALU_OPISO_EN
    assign w_s1_load = in_valid && w_in_ready;
    // Idle cycles present all-zero operands so the adder and shifter do not toggle.
    assign w_ua      = r_s1_valid ? r_s1_a  : '0;
    assign w_ub      = r_s1_valid ? r_s1_b  : '0;
    assign w_uop     = r_s1_valid ? r_s1_op : 4'd0;
`else
    assign w_s1_load = w_in_ready;
    assign w_ua      = r_s1_a;
    assign w_ub      = r_s1_b;
    assign w_uop     = r_s1_op;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= 4'd0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load) begin
                r_s1_a  <= a;
                r_s1_b  <= b;
                r_s1_op <= op;
            end
        end
    end

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_add_ovf;

    cla_addsub_n #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (w_ua),
        .b    (w_ub),
        .sub  (w_uop == OpSub),
        .sum  (w_sum),
        .cout (w_cout),
        .ovf  (w_add_ovf)
    );

    logic [SHW-1:0]         w_sh;
    logic [WIDTH:0]         w_shl_ext;
    logic [WIDTH:0]         w_shr_ext;
    logic signed [WIDTH:0]  w_sra_ext;
    logic [2*WIDTH-1:0]     w_rol_ext;
    logic                   w_slt;
    logic                   w_sltu;

    // Extra bit on each shift catches the last bit shifted out; it is 0 for a zero amount.
    assign w_sh      = w_ub[SHW-1:0];
    assign w_shl_ext = {1'b0, w_ua} << w_sh;
    assign w_shr_ext = {w_ua, 1'b0} >> w_sh;
    assign w_sra_ext = $signed({w_ua, 1'b0}) >>> w_sh;
    assign w_rol_ext = {w_ua, w_ua} << w_sh;
    assign w_slt     = $signed(w_ua) < $signed(w_ub);
    assign w_sltu    = w_ua < w_ub;

    logic [WIDTH-1:0] w_res;
    logic             w_cy;
    logic             w_ov;
    logic             w_ill;
    alu_flags_t       w_flags;

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ov  = 1'b0;
        w_ill = op_is_illegal(w_uop);
        case (w_uop)
            OpAdd, OpSub: begin
                w_res = w_sum;
                w_cy  = w_cout;
                w_ov  = w_add_ovf;
            end
            OpAnd:  w_res = w_ua & w_ub;
            OpOr:   w_res = w_ua | w_ub;
            OpXor:  w_res = w_ua ^ w_ub;
            OpNot:  w_res = ~w_ua;
            OpShl: begin
                w_res = w_shl_ext[WIDTH-1:0];
                w_cy  = w_shl_ext[WIDTH];
            end
            OpShr: begin
                w_res = w_shr_ext[WIDTH:1];
                w_cy  = w_shr_ext[0];
            end
            OpSra: begin
                w_res = w_sra_ext[WIDTH:1];
                w_cy  = w_sra_ext[0];
            end
            OpRol:  w_res = w_rol_ext[2*WIDTH-1:WIDTH];
            OpSlt:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OpSltu: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
            default: ;
        endcase
    end

    always_comb begin
        w_flags         = '0;
        w_flags.carry   = w_cy;
        w_flags.zero    = (w_res == '0);
        w_flags.neg     = w_res[WIDTH-1];
        w_flags.ovf     = w_ov;
        w_flags.illegal = w_ill;
    end

    // Result registers only capture real beats, so both builds emit identical output traces.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y     <= w_res;
                r_flags <= w_flags;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign carry     = r_flags.carry;
    assign zero      = r_flags.zero;
    assign neg       = r_flags.neg;
    assign ovf       = r_flags.ovf;
    assign illegal   = r_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=16): latency, ops/flags, backpressure, mid-flight reset.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        carry;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        illegal;

    alu_pipe #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // f = {carry, zero, neg, ovf, illegal}
    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic [4:0]  f;
    } vec_t;

    vec_t vt [21];
    vec_t exp_q [$];
    vec_t cur;
    vec_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;

    function automatic vec_t mk(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb,
                                input logic [15:0] vy, input logic [4:0] vf);
        vec_t v;
        v.op = o;
        v.a  = va;
        v.b  = vb;
        v.y  = vy;
        v.f  = vf;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq($sformatf("y op%0d a=%h b=%h", mon_e.op, mon_e.a, mon_e.b),
                         {16'b0, y}, {16'b0, mon_e.y});
                check_eq($sformatf("flags op%0d a=%h b=%h", mon_e.op, mon_e.a, mon_e.b),
                         {27'b0, carry, zero, neg, ovf, illegal}, {27'b0, mon_e.f});
            end
        end
        if (in_valid && in_ready) begin
            n_acc++;
            exp_q.push_back(cur);
        end
    end

    task automatic send(input vec_t v);
        int k;
        cur      = v;
        op       = v.op;
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
        k        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                check_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("drain_empty", exp_q.size(), 32'd0);
    endtask

    logic [15:0] y_hold;
    int          acc0;

    initial begin
        vt[0]  = mk(OpAdd,  16'hFFFF, 16'h0001, 16'h0000, 5'b11000);
        vt[1]  = mk(OpAdd,  16'h7FFF, 16'h0001, 16'h8000, 5'b00110);
        vt[2]  = mk(OpSub,  16'h0000, 16'h0001, 16'hFFFF, 5'b00100);
        vt[3]  = mk(OpShl,  16'h8001, 16'h0001, 16'h0002, 5'b10000);
        vt[4]  = mk(OpSra,  16'h8000, 16'h000F, 16'hFFFF, 5'b00100);
        vt[5]  = mk(OpRol,  16'h8001, 16'h0004, 16'h0018, 5'b00000);
        vt[6]  = mk(OpSlt,  16'hFFFF, 16'h0001, 16'h0001, 5'b00000);
        vt[7]  = mk(OpSltu, 16'hFFFF, 16'h0001, 16'h0000, 5'b01000);
        vt[8]  = mk(4'hD,   16'h1234, 16'h5678, 16'h0000, 5'b01001);
        vt[9]  = mk(OpSub,  16'h0005, 16'h0003, 16'h0002, 5'b10000);
        vt[10] = mk(OpShr,  16'h0003, 16'h0001, 16'h0001, 5'b10000);
        vt[11] = mk(OpAnd,  16'hF0F0, 16'hFF00, 16'hF000, 5'b00100);
        vt[12] = mk(OpOr,   16'h0F0F, 16'hF000, 16'hFF0F, 5'b00100);
        vt[13] = mk(OpXor,  16'hAAAA, 16'hAAAA, 16'h0000, 5'b01000);
        vt[14] = mk(OpNot,  16'h00FF, 16'h1234, 16'hFF00, 5'b00100);
        vt[15] = mk(OpShl,  16'h1234, 16'h0010, 16'h1234, 5'b00000);
        vt[16] = mk(OpSub,  16'h8000, 16'h0001, 16'h7FFF, 5'b10010);
        vt[17] = mk(OpSlt,  16'h0001, 16'hFFFF, 16'h0000, 5'b01000);
        vt[18] = mk(OpSltu, 16'h0001, 16'hFFFF, 16'h0001, 5'b00000);
        vt[19] = mk(OpSra,  16'h8003, 16'h0001, 16'hC001, 5'b10100);
        vt[20] = mk(OpAdd,  16'h8000, 16'h8000, 16'h0000, 5'b11010);

        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        op        = 4'd0;
        cur       = vt[0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("rst_y", {16'b0, y}, 32'd0);
        check_eq("rst_flags", {27'b0, carry, zero, neg, ovf, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", {31'b0, in_ready}, 32'd1);
        check_eq("idle_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Single beat: out_valid rises one edge after the accepting edge.
        send(vt[0]);
        check_eq("lat_s1", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("lat_s2", {31'b0, out_valid}, 32'd1);
        drain();

        for (int i = 1; i < 21; i++) send(vt[i]);
        drain();

        // Backpressure: 8 beats offered while the sink stalls for 5 cycles.
        out_ready = 1'b0;
        acc0      = n_acc;
        y_hold    = '0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vt[10 + i]);
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    if (c == 1) y_hold = y;
                    if (c > 1) check_eq("stall_y_stable", {16'b0, y}, {16'b0, y_hold});
                end
                check_eq("stall_y_first", {16'b0, y_hold}, {16'b0, vt[10].y});
                check_eq("stall_accepted", n_acc - acc0, 32'd2);
                check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
                check_eq("stall_out_valid", {31'b0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("out_count", n_out, n_acc);

        // Reset with two beats in flight and the sink stalled.
        out_ready = 1'b0;
        send(vt[3]);
        send(vt[4]);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("flush_y", {16'b0, y}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_eq("no_stale", {31'b0, out_valid}, 32'd0);
        end

        for (int i = 2; i < 6; i++) send(vt[i]);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
